// File: rtl/pong_pkg.sv
// Shared constants and button indexing for the pong push-button front end.
package pong_pkg;

    localparam int CLK_HZ              = 25175000;
    localparam int DEBOUNCE_CYCLES_DEF = 251750;    // 10 ms
    localparam int REPEAT_DELAY_DEF    = 12587500;  // 500 ms
    localparam int REPEAT_CYCLES_DEF   = 2517500;   // 100 ms

    localparam int NUM_BTN = 5;
    localparam int NUM_DIR = 4;

    // Bit positions in the per-button vectors; directions pair up as gi / gi^1.
    typedef enum logic [2:0] {
        LU = 3'd0,
        LD = 3'd1,
        RU = 3'd2,
        RD = 3'd3,
        SR = 3'd4
    } btn_idx_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button channel: two-flop synchronizer, hold counter and stable state.
// The stable level toggles once the synchronized input has differed for DEBOUNCE_CYCLES cycles.
module btn_debounce
    import pong_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
)(
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_stable
);

    localparam int              CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_stable;
    logic [CW-1:0] r_cnt;

    // The counter tops out at CNT_LAST and is cleared there, so it never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_stable <= ~r_stable;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_stable = r_stable;

endmodule

// File: rtl/pong_input.sv
// Pong controller front end: debounced paddle levels, step pulses and score-clear pulse.
// Define PONG_AUTOREPEAT_EN to add held-button auto-repeat pulses on the four directions.
module pong_input
    import pong_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEF
)(
    input  logic clk,
    input  logic rst_n,
    input  logic btn_left_up,
    input  logic btn_left_down,
    input  logic btn_right_up,
    input  logic btn_right_down,
    input  logic btn_score_reset,
    output logic left_up,
    output logic left_down,
    output logic right_up,
    output logic right_down,
    output logic left_up_pls,
    output logic left_down_pls,
    output logic right_up_pls,
    output logic right_down_pls,
    output logic score_reset
);

    logic [NUM_BTN-1:0] w_raw;
    logic [NUM_BTN-1:0] w_stable;
    logic [NUM_DIR-1:0] w_level_next;
    logic [NUM_DIR-1:0] w_rep_pls;
    logic [NUM_DIR-1:0] r_level;
    logic [NUM_DIR-1:0] r_pls;
    logic               r_sr_prev;
    logic               r_score_reset;

    assign w_raw = {btn_score_reset, btn_right_down, btn_right_up, btn_left_down, btn_left_up};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
            btn_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk      (clk),
                .rst_n    (rst_n),
                .i_raw    (w_raw[gi]),
                .o_stable (w_stable[gi])
            );
        end

        // Opposing directions of one paddle cancel each other out.
        for (gi = 0; gi < NUM_DIR; gi++) begin : g_level
            assign w_level_next[gi] = w_stable[gi] & ~w_stable[gi ^ 1];
        end
    endgenerate

`ifdef PONG_AUTOREPEAT_EN
    localparam int RW = $clog2(max_int(REPEAT_DELAY, REPEAT_CYCLES));

    generate
        for (gi = 0; gi < NUM_DIR; gi++) begin : g_repeat
            logic [RW-1:0] r_rep_cnt;
            logic          r_rep_phase;
            logic          w_rep_fire;

            assign w_rep_fire = r_rep_phase ? (r_rep_cnt == RW'(REPEAT_CYCLES - 1))
                                            : (r_rep_cnt == RW'(REPEAT_DELAY - 1));

            // Counting restarts on the rising edge and stops the cycle the level drops.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_rep_cnt   <= '0;
                    r_rep_phase <= 1'b0;
                end else if (!w_level_next[gi] || !r_level[gi]) begin
                    r_rep_cnt   <= '0;
                    r_rep_phase <= 1'b0;
                end else if (w_rep_fire) begin
                    r_rep_cnt   <= '0;
                    r_rep_phase <= 1'b1;
                end else if (r_rep_cnt != '1) begin
                    r_rep_cnt <= r_rep_cnt + 1'b1;
                end
            end

            assign w_rep_pls[gi] = r_level[gi] & w_level_next[gi] & w_rep_fire;
        end
    endgenerate
`else
    // Repeat timing has no hardware here; referenced only so both builds share one parameter list.
    localparam bit REPEAT_CFG_OK = (REPEAT_DELAY > 1) && (REPEAT_CYCLES > 0);
    generate
        if (!REPEAT_CFG_OK) begin : g_repeat_cfg_unused
        end
    endgenerate
    assign w_rep_pls = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level       <= '0;
            r_pls         <= '0;
            r_sr_prev     <= 1'b0;
            r_score_reset <= 1'b0;
        end else begin
            r_level       <= w_level_next;
            r_pls         <= (w_level_next & ~r_level) | w_rep_pls;
            r_sr_prev     <= w_stable[SR];
            r_score_reset <= w_stable[SR] & ~r_sr_prev;
        end
    end

    assign left_up        = r_level[0];
    assign left_down      = r_level[1];
    assign right_up       = r_level[2];
    assign right_down     = r_level[3];
    assign left_up_pls    = r_pls[0];
    assign left_down_pls  = r_pls[1];
    assign right_up_pls   = r_pls[2];
    assign right_down_pls = r_pls[3];
    assign score_reset    = r_score_reset;

endmodule

// File: doc/pong_input.md
PONG_INPUT -- requirements
Module: pong_input

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 251750, cycles a raw input must hold a new level before it is accepted (10 ms at 25.175 MHz).
REQ-002 Parameter REPEAT_DELAY, default 12587500, cycles a press is held before auto-repeat starts (500 ms).
REQ-003 Parameter REPEAT_CYCLES, default 2517500, cycles between auto-repeat pulses (100 ms).
REQ-004 Port clk, input, 1, the single clock domain of the block.
REQ-005 Port rst_n, input, 1, asynchronous active-low reset.
REQ-006 Ports btn_left_up, btn_left_down, btn_right_up, btn_right_down, btn_score_reset, input, 1 each, raw asynchronous push-buttons, active-high.
REQ-007 Ports left_up, left_down, right_up, right_down, output, 1 each, debounced held level per direction for the game-logic stage.
REQ-008 Ports left_up_pls, left_down_pls, right_up_pls, right_down_pls, output, 1 each, one-cycle step request per direction.
REQ-009 Port score_reset, output, 1, one-cycle score-clear pulse.

Function
REQ-010 Each raw input shall pass through a two-flop synchronizer before any other logic.
REQ-011 Each channel shall hold a stable state and a counter; the counter increments while the synchronized input differs from the stable state and clears when they match.
REQ-012 When the counter reaches DEBOUNCE_CYCLES-1 with the input still differing, the stable state shall toggle and the counter shall clear; glitches shorter than DEBOUNCE_CYCLES are rejected.
REQ-013 Press-to-level latency shall be exactly 2 + DEBOUNCE_CYCLES + 1 cycles from the first clk edge that samples the new raw level.
REQ-014 Level outputs shall be registered: left_up = stable_lu AND NOT stable_ld, and likewise for the other three directions; opposing directions held together give both levels low.
REQ-015 A direction pulse shall assert for exactly one cycle on the cycle its level output rises.
REQ-016 score_reset shall pulse for one cycle on each rising edge of the stable score-reset state and never repeat while held.
REQ-017 Counter widths shall be $clog2 of the respective parameter; counters saturate and never wrap.
REQ-018 A level dropping mid-repeat shall clear that channel's repeat counter in the same cycle, with no further pulses.

Reset
REQ-019 While rst_n is low, all synchronizer flops, stable states, counters and outputs shall be 0, whatever the button inputs.
REQ-020 After rst_n is released, a button already held shall be accepted as a fresh press following the full REQ-013 latency.

Configuration
REQ-021 With PONG_AUTOREPEAT_EN defined, a direction level held for REPEAT_DELAY cycles after its rising pulse shall produce one pulse, then one pulse every REPEAT_CYCLES cycles while held.
REQ-022 Without PONG_AUTOREPEAT_EN, only the rising-edge pulse of REQ-015 exists, the repeat counters are absent, and REPEAT_DELAY and REPEAT_CYCLES are unused.

Structure
REQ-023 Package pong_pkg shall hold CLK_HZ (25175000), the default debounce, delay and repeat cycle constants, and the button index enum (LU, LD, RU, RD, SR).
REQ-024 Sub-module btn_debounce shall implement one channel (synchronizer, counter, stable state), instantiated five times.

Verification
REQ-025 DEBOUNCE_CYCLES=8: btn_left_up high for 7 cycles then low -> left_up and left_up_pls stay 0.
REQ-026 DEBOUNCE_CYCLES=8: btn_left_up held -> left_up rises on cycle 11 with left_up_pls high for that cycle only.
REQ-027 Autorepeat on, REPEAT_DELAY=32, REPEAT_CYCLES=16, btn_right_down held 100 cycles -> pulses at 11, 43, 59, 75, 91 and none after release.
REQ-028 btn_left_up and btn_left_down held together -> left_up=left_down=0; release left_down -> left_up rises after debounce.
REQ-029 btn_score_reset held 200 cycles -> exactly one score_reset pulse.
REQ-030 rst_n pulsed low mid-repeat -> all outputs 0 at once; button still held -> fresh press after 11 cycles.
